// File: rtl/barrier_types.sv
// Shared barrier types: release event record and wake walker states.
package barrier_types;
  localparam int BARRIER_MAX_WARPS = 32;

  typedef struct packed {
    logic [15:0]                  barrier_id;
    logic [9:0]                   block_id;
    logic [BARRIER_MAX_WARPS-1:0] warp_mask;
  } barrier_release_t;

  typedef enum logic {WAKE_IDLE, WAKE_ACTIVE} wake_state_e;
endpackage

// File: rtl/barrier_release_fifo.sv
// Synchronous FIFO of barrier release records; head entry is visible while not empty.
module barrier_release_fifo
  import barrier_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  barrier_release_t push_data_i,
  input  logic             pop_i,
  output barrier_release_t head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  barrier_release_t mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/barrier_wake_dispatcher.sv
// Buffers barrier releases and serialises each warp mask into per-warp wake events.
// Define BARRIER_WAKE_STATS_EN to build the wake/empty-release statistics counters.
module barrier_wake_dispatcher
  import barrier_types::*;
#(
  parameter int WARPS_PER_BLOCK = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                rel_barrier_id,
  input  logic [9:0]                 rel_block_id,
  input  logic [WARPS_PER_BLOCK-1:0] rel_warp_mask,
  input  logic                       rel_valid,
  output logic                       rel_ready,
  output logic [15:0]                wake_barrier_id,
  output logic [9:0]                 wake_block_id,
  output logic [5:0]                 wake_warp_id,
  output logic                       wake_valid,
  input  logic                       wake_ready,
  output logic                       busy,
  output logic [31:0]                wake_count,
  output logic [31:0]                empty_release_count,
  output wake_state_e                dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid and payload never depend combinationally on ready.

  function automatic logic [5:0] lowest_set(input logic [WARPS_PER_BLOCK-1:0] m);
    logic [5:0] idx;
    idx = '0;
    for (int i = WARPS_PER_BLOCK - 1; i >= 0; i--)
      if (m[i]) idx = 6'(i);
    return idx;
  endfunction

  barrier_release_t            push_data, fifo_head;
  logic                        fifo_full, fifo_empty, fifo_pop;
  logic [WARPS_PER_BLOCK-1:0]  head_mask, remaining;
  logic                        wake_hs;

  wake_state_e                 state_q, state_d;
  logic [15:0]                 cur_barrier_q, cur_barrier_d;
  logic [9:0]                  cur_block_q, cur_block_d;
  logic [WARPS_PER_BLOCK-1:0]  cur_mask_q, cur_mask_d;
  logic [5:0]                  warp_q, warp_d;

  assign push_data.barrier_id = rel_barrier_id;
  assign push_data.block_id   = rel_block_id;
  assign push_data.warp_mask  = BARRIER_MAX_WARPS'(rel_warp_mask);
  assign head_mask            = WARPS_PER_BLOCK'(fifo_head.warp_mask);

  barrier_release_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rel_valid),
    .push_data_i (push_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign wake_hs   = (state_q == WAKE_ACTIVE) && wake_ready;
  assign remaining = cur_mask_q & (cur_mask_q - WARPS_PER_BLOCK'(1));

  always_comb begin
    state_d       = state_q;
    cur_barrier_d = cur_barrier_q;
    cur_block_d   = cur_block_q;
    cur_mask_d    = cur_mask_q;
    warp_d        = warp_q;
    fifo_pop      = 1'b0;
    // Loading happens from IDLE or on the final wake of a mask, so queued releases run back-to-back.
    if (state_q == WAKE_IDLE || (wake_hs && remaining == '0)) begin
      state_d    = WAKE_IDLE;
      cur_mask_d = '0;
      if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        cur_mask_d = head_mask;
        if (head_mask != '0) begin
          state_d       = WAKE_ACTIVE;
          cur_barrier_d = fifo_head.barrier_id;
          cur_block_d   = fifo_head.block_id;
          warp_d        = lowest_set(head_mask);
        end
      end
    end else if (wake_hs) begin
      cur_mask_d = remaining;
      warp_d     = lowest_set(remaining);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAKE_IDLE;
      cur_barrier_q <= '0;
      cur_block_q   <= '0;
      cur_mask_q    <= '0;
      warp_q        <= '0;
    end else begin
      state_q       <= state_d;
      cur_barrier_q <= cur_barrier_d;
      cur_block_q   <= cur_block_d;
      cur_mask_q    <= cur_mask_d;
      warp_q        <= warp_d;
    end
  end

  assign rel_ready       = !fifo_full;
  assign wake_valid      = (state_q == WAKE_ACTIVE);
  assign wake_barrier_id = cur_barrier_q;
  assign wake_block_id   = cur_block_q;
  assign wake_warp_id    = warp_q;
  assign busy            = !fifo_empty || wake_valid;
  assign dbg_state       = state_q;

`ifdef BARRIER_WAKE_STATS_EN
  logic [31:0] wake_cnt_q, empty_cnt_q;
  logic        zero_pop;

  assign zero_pop = fifo_pop && (head_mask == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wake_cnt_q  <= '0;
      empty_cnt_q <= '0;
    end else begin
      if (wake_hs)  wake_cnt_q  <= wake_cnt_q + 32'd1;
      if (zero_pop) empty_cnt_q <= empty_cnt_q + 32'd1;
    end
  end

  assign wake_count          = wake_cnt_q;
  assign empty_release_count = empty_cnt_q;
`else
  assign wake_count          = 32'h0;
  assign empty_release_count = 32'h0;
`endif
endmodule

// File: tb/tb_barrier_wake_dispatcher.sv
// Directed bench for barrier_wake_dispatcher: per-cycle vector table plus multi-cycle sequences.
module tb_barrier_wake_dispatcher;
  import barrier_types::*;

  localparam int W = 22;  // {barrier_id, warp_id} scoreboard entry

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rel_barrier_id;
  logic [9:0]  rel_block_id;
  logic [31:0] rel_warp_mask;
  logic        rel_valid;
  logic        rel_ready;
  logic [15:0] wake_barrier_id;
  logic [9:0]  wake_block_id;
  logic [5:0]  wake_warp_id;
  logic        wake_valid;
  logic        wake_ready;
  logic        busy;
  logic [31:0] wake_count;
  logic [31:0] empty_release_count;
  wake_state_e dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  barrier_wake_dispatcher #(.WARPS_PER_BLOCK(32), .FIFO_DEPTH(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rel_barrier_id      (rel_barrier_id),
    .rel_block_id        (rel_block_id),
    .rel_warp_mask       (rel_warp_mask),
    .rel_valid           (rel_valid),
    .rel_ready           (rel_ready),
    .wake_barrier_id     (wake_barrier_id),
    .wake_block_id       (wake_block_id),
    .wake_warp_id        (wake_warp_id),
    .wake_valid          (wake_valid),
    .wake_ready          (wake_ready),
    .busy                (busy),
    .wake_count          (wake_count),
    .empty_release_count (empty_release_count),
    .dbg_state           (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [15:0] bar;
    logic [9:0]  blk;
    logic [31:0] mask;
    logic        wr;
    logic        e_rr;
    logic        e_wv;
    logic [5:0]  e_warp;
    logic [15:0] e_bar;
    logic [9:0]  e_blk;
    logic        e_busy;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic rv, logic [15:0] bar, logic [9:0] blk, logic [31:0] mask,
                              logic wr, logic e_rr, logic e_wv, logic [5:0] e_warp,
                              logic [15:0] e_bar, logic [9:0] e_blk, logic e_busy);
    vec_t v;
    v.rv = rv; v.bar = bar; v.blk = blk; v.mask = mask; v.wr = wr;
    v.e_rr = e_rr; v.e_wv = e_wv; v.e_warp = e_warp;
    v.e_bar = e_bar; v.e_blk = e_blk; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver
  task automatic drive(input logic rv, input logic [15:0] bar, input logic [9:0] blk,
                       input logic [31:0] mask, input logic wr);
    rel_valid      = rv;
    rel_barrier_id = bar;
    rel_block_id   = blk;
    rel_warp_mask  = mask;
    wake_ready     = wr;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rel_ready"},  64'(rel_ready), 64'(1));
    check({tag, "_wake_valid"}, 64'(wake_valid), 64'(0));
    check({tag, "_warp_id"},    64'(wake_warp_id), 64'(0));
    check({tag, "_barrier_id"}, 64'(wake_barrier_id), 64'(0));
    check({tag, "_block_id"},   64'(wake_block_id), 64'(0));
    check({tag, "_busy"},       64'(busy), 64'(0));
    check({tag, "_state"},      64'(dbg_state), 64'(WAKE_IDLE));
    check({tag, "_wake_count"}, 64'(wake_count), 64'(0));
    check({tag, "_empty_count"}, 64'(empty_release_count), 64'(0));
  endtask

  function automatic logic [31:0] stat_exp(input logic [31:0] v);
`ifdef BARRIER_WAKE_STATS_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  initial begin
    int accepted;
    int hs;
    int seen;
    logic [W-1:0] e;

    vecs[0]  = mk(1, 16'd7,  10'd3, 32'h5,         1, 1, 0, 0,  0,  0, 0);
    vecs[1]  = mk(0, 16'd0,  10'd0, 32'h0,         1, 1, 0, 0,  0,  0, 1);
    vecs[2]  = mk(0, 16'd0,  10'd0, 32'h0,         1, 1, 1, 0,  7,  3, 1);
    vecs[3]  = mk(0, 16'd0,  10'd0, 32'h0,         1, 1, 1, 2,  7,  3, 1);
    vecs[4]  = mk(0, 16'd0,  10'd0, 32'h0,         1, 1, 0, 0,  0,  0, 0);
    vecs[5]  = mk(1, 16'd9,  10'd1, 32'h8000_0000, 1, 1, 0, 0,  0,  0, 0);
    vecs[6]  = mk(1, 16'd10, 10'd2, 32'h1,         1, 1, 0, 0,  0,  0, 1);
    vecs[7]  = mk(0, 16'd0,  10'd0, 32'h0,         1, 1, 1, 31, 9,  1, 1);
    vecs[8]  = mk(0, 16'd0,  10'd0, 32'h0,         1, 1, 1, 0,  10, 2, 1);
    vecs[9]  = mk(0, 16'd0,  10'd0, 32'h0,         1, 1, 0, 0,  0,  0, 0);
    vecs[10] = mk(1, 16'd5,  10'd5, 32'h0,         1, 1, 0, 0,  0,  0, 0);
    vecs[11] = mk(0, 16'd0,  10'd0, 32'h0,         1, 1, 0, 0,  0,  0, 1);
    vecs[12] = mk(0, 16'd0,  10'd0, 32'h0,         1, 1, 0, 0,  0,  0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table: two-bit mask, back-to-back 0x8000_0000/0x1, zero-mask release
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].rv, vecs[i].bar, vecs[i].blk, vecs[i].mask, vecs[i].wr);
      #1;
      check($sformatf("v%0d_rel_ready", i), 64'(rel_ready), 64'(vecs[i].e_rr));
      check($sformatf("v%0d_wake_valid", i), 64'(wake_valid), 64'(vecs[i].e_wv));
      check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      if (vecs[i].e_wv) begin
        check($sformatf("v%0d_warp", i), 64'(wake_warp_id), 64'(vecs[i].e_warp));
        check($sformatf("v%0d_bar", i), 64'(wake_barrier_id), 64'(vecs[i].e_bar));
        check($sformatf("v%0d_blk", i), 64'(wake_block_id), 64'(vecs[i].e_blk));
      end
    end
    check("wake_count_after_table", 64'(wake_count), 64'(stat_exp(32'd4)));
    check("empty_count_after_table", 64'(empty_release_count), 64'(stat_exp(32'd1)));

    // Back-pressure hold: mask 0x6 stalls on warp1 for 5 cycles
    @(negedge clk);
    drive(1, 16'd42, 10'd8, 32'h6, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("stall%0d_valid", c), 64'(wake_valid), 64'(1));
      check($sformatf("stall%0d_warp", c), 64'(wake_warp_id), 64'(1));
      check($sformatf("stall%0d_bar", c), 64'(wake_barrier_id), 64'(42));
    end
    @(negedge clk);
    wake_ready = 1'b1;
    #1 check("stall_release_warp1", 64'(wake_warp_id), 64'(1));
    @(negedge clk);
    #1;
    check("stall_release_warp2", 64'(wake_warp_id), 64'(2));
    check("stall_release_valid2", 64'(wake_valid), 64'(1));
    @(negedge clk);
    #1 check("stall_done_valid", 64'(wake_valid), 64'(0));

    // Fill under back-pressure: 5 accepted, 6th refused, drain in order
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(1, 16'(100 + k), 10'(k), 32'h1 << k, 0);
      #1;
      check($sformatf("fill%0d_rel_ready", k), 64'(rel_ready), 64'(k < 5));
      if (k < 5) begin
        exp_q.push_back({16'(100 + k), 6'(k)});
        accepted++;
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      #1;
      if (wake_valid) begin
        e = exp_q.pop_front();
        check("drain_wake", 64'({wake_barrier_id, wake_warp_id}), 64'(e));
      end
      @(negedge clk);
    end
    check("drain_leftover", 64'(exp_q.size()), 64'(0));
    #1;
    check("drain_idle_valid", 64'(wake_valid), 64'(0));
    check("drain_idle_busy", 64'(busy), 64'(0));
    check("wake_count_after_drain", 64'(wake_count), 64'(stat_exp(32'd4 + 32'd2 + 32'(accepted))));

    // Reset mid-walk of mask 0xFF after 3 wakes, with another release queued
    @(negedge clk);
    drive(1, 16'd20, 10'd4, 32'hFF, 1);
    @(negedge clk);
    drive(1, 16'd21, 10'd5, 32'h3, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    hs = 0;
    for (int c = 0; c < 20 && hs < 3; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (wake_valid) begin
        check($sformatf("walk_warp%0d", hs), 64'(wake_warp_id), 64'(hs));
        hs++;
      end
    end
    check("walk_three_wakes", 64'(hs), 64'(3));
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("midwalk");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (wake_valid) seen++;
    end
    check("post_reset_wakes", 64'(seen), 64'(0));
    check("post_reset_busy", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
